// File: rtl/coa_pkg.sv
`default_nettype none
// ============================================================================
// Package  : coa_pkg
// Brief    : Shared constants and state encoding for the DBNZ loop controller.
// Revision : 1.0
// ============================================================================
package coa_pkg;

    localparam int c_default_width = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } loop_state_t;

endpackage : coa_pkg
`default_nettype wire

// File: rtl/zero_det.sv
`default_nettype none
// ============================================================================
// Module   : zero_det
// Brief    : Combinational all-zero detector for a WIDTH-bit value.
// Revision : 1.0
// ============================================================================
module zero_det #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_value,
    output logic             o_zero
);

    assign o_zero = (i_value == '0);

endmodule : zero_det
`default_nettype wire

// File: rtl/dbnz_loop_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dbnz_loop_ctrl
// Brief    : Decrement-and-branch-if-nonzero loop controller (IDLE/RUN/DONE).
// Revision : 1.0
// ============================================================================
module dbnz_loop_ctrl
    import coa_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             step,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             branch,
    output logic             done,
    output logic             zero
);

    loop_state_t      r_state;
    loop_state_t      w_state_next;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;
    logic [WIDTH-1:0] w_dec;
    logic             r_branch;
    logic             r_done;
    logic             w_branch_next;
    logic             w_done_next;
    logic             w_count_zero;
    logic             w_load_zero;
    logic             w_dec_zero;

    assign w_dec = r_count - WIDTH'(1);

    zero_det #(.WIDTH(WIDTH)) u_zero_count (
        .i_value (r_count),
        .o_zero  (w_count_zero)
    );

    zero_det #(.WIDTH(WIDTH)) u_zero_load (
        .i_value (load_val),
        .o_zero  (w_load_zero)
    );

    zero_det #(.WIDTH(WIDTH)) u_zero_dec (
        .i_value (w_dec),
        .o_zero  (w_dec_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_branch <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_count  <= w_count_next;
            r_branch <= w_branch_next;
            r_done   <= w_done_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_count_next  = r_count;
        w_branch_next = 1'b0;
        w_done_next   = 1'b0;
        case (r_state)
            IDLE, RUN: begin
                // A load restarts the loop from either state and swallows any step.
                if (load) begin
                    w_count_next = load_val;
                    if (w_load_zero) begin
                        w_state_next = DONE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_state_next = RUN;
                    end
                end else if ((r_state == RUN) && step) begin
                    w_count_next = w_dec;
                    if (w_dec_zero) begin
                        w_state_next = DONE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_branch_next = 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign count  = r_count;
    assign busy   = (r_state == RUN);
    assign branch = r_branch;
    assign done   = r_done;
    assign zero   = w_count_zero;

endmodule : dbnz_loop_ctrl
`default_nettype wire

// File: tb/tb_dbnz_loop_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dbnz_loop_ctrl
// Brief    : Self-checking bench for dbnz_loop_ctrl with a queued reference model.
// Revision : 1.0
// ============================================================================
module tb_dbnz_loop_ctrl;

    typedef struct packed {
        logic [7:0] count;
        logic       busy;
        logic       branch;
        logic       done;
        logic       zero;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [7:0] load_val;
    logic       step;
    logic [7:0] count;
    logic       busy;
    logic       branch;
    logic       done;
    logic       zero;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    // Reference model state: 0 = idle, 1 = run, 2 = done.
    int         m_state = 0;
    logic [7:0] m_count = 8'd0;

    dbnz_loop_ctrl #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .step     (step),
        .count    (count),
        .busy     (busy),
        .branch   (branch),
        .done     (done),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    function automatic obs_t observe();
        return {count, busy, branch, done, zero};
    endfunction

    task automatic drive(input logic r, input logic ld, input logic [7:0] v, input logic st);
        logic m_branch;
        logic m_done;
        m_branch = 1'b0;
        m_done   = 1'b0;
        if (r) begin
            m_state = 0;
            m_count = 8'd0;
        end else if (m_state == 2) begin
            m_state = 0;
        end else if (ld) begin
            m_count = v;
            if (v == 8'd0) begin
                m_state = 2;
                m_done  = 1'b1;
            end else begin
                m_state = 1;
            end
        end else if (m_state == 1 && st) begin
            m_count = m_count - 8'd1;
            if (m_count == 8'd0) begin
                m_state = 2;
                m_done  = 1'b1;
            end else begin
                m_branch = 1'b1;
            end
        end
        exp_q.push_back({m_count, (m_state == 1), m_branch, m_done, (m_count == 8'd0)});
        rst      = r;
        load     = ld;
        load_val = v;
        step     = st;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 8'd9, 1'b1);
            got = observe();
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_sb got=%h exp=%h", got, exp);
            end
        end
        checks++;
        if (got !== {8'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", got, {8'd0, 4'b0001});
        end
    endtask

    task automatic test_count3();
        obs_t       got, exp;
        int         nbr, ndn;
        logic [7:0] seq [3];
        seq[0] = 8'd2; seq[1] = 8'd1; seq[2] = 8'd0;
        nbr = 0;
        ndn = 0;
        drive(1'b0, 1'b1, 8'd3, 1'b0);
        got = observe();
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL count3_load got=%h exp=%h", got, exp);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 8'd0, 1'b1);
            got = observe();
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            nbr += int'(branch);
            ndn += int'(done);
            checks++;
            if (got !== exp || count !== seq[i]) begin
                errors++;
                $display("FAIL count3_step%0d got=%h exp=%h count_exp=%0d", i, got, exp, seq[i]);
            end
        end
        checks++;
        if (nbr != 2 || ndn != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL count3_pulses got branch=%0d done=%0d busy=%b exp 2 1 0", nbr, ndn, busy);
        end
        drive(1'b0, 1'b0, 8'd0, 1'b0);
        got = observe();
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL count3_exit got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_load_zero();
        obs_t got, exp;
        drive(1'b0, 1'b1, 8'd0, 1'b0);
        got = observe();
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (got !== exp || got !== {8'd0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL load_zero got=%h exp=%h", got, exp);
        end
        drive(1'b0, 1'b0, 8'd0, 1'b0);
        got = observe();
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (got !== exp || done !== 1'b0) begin
            errors++;
            $display("FAIL load_zero_after got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_reload();
        obs_t got, exp;
        drive(1'b0, 1'b1, 8'd5, 1'b0);
        drive(1'b0, 1'b0, 8'd0, 1'b1);
        drive(1'b0, 1'b0, 8'd0, 1'b1);
        drive(1'b0, 1'b1, 8'd2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            got = (i == 3) ? observe() : got;
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        end
        checks++;
        if (got !== exp || got !== {8'd2, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reload got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_reset_midloop();
        obs_t got, exp;
        drive(1'b0, 1'b1, 8'd4, 1'b0);
        void'(exp_q.pop_front());
        checks++;
        if (count !== 8'd4 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midloop_setup got count=%0d busy=%b exp 4 1", count, busy);
        end
        drive(1'b1, 1'b1, 8'd7, 1'b1);
        got = observe();
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (got !== exp || got !== {8'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_in_run got=%h exp=%h", got, exp);
        end
        drive(1'b0, 1'b1, 8'd0, 1'b0);
        void'(exp_q.pop_front());
        drive(1'b1, 1'b1, 8'd7, 1'b1);
        got = observe();
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (got !== exp || got !== {8'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_in_done got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_ignored_step();
        obs_t got, exp;
        drive(1'b0, 1'b0, 8'd0, 1'b1);
        got = observe();
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (got !== exp || got !== {8'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL step_in_idle got=%h exp=%h", got, exp);
        end
        drive(1'b0, 1'b1, 8'd0, 1'b0);
        void'(exp_q.pop_front());
        // Step and a fresh load during DONE must both be dropped.
        drive(1'b0, 1'b1, 8'd9, 1'b1);
        got = observe();
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (got !== exp || got !== {8'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL step_in_done got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_back_to_back();
        obs_t got, exp;
        int   nbr, ndn, bad;
        nbr = 0;
        ndn = 0;
        bad = 0;
        drive(1'b0, 1'b1, 8'd255, 1'b0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 255; i++) begin
            drive(1'b0, 1'b0, 8'd0, 1'b1);
            got = observe();
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            nbr += int'(branch);
            ndn += int'(done);
            checks++;
            if (got !== exp) begin
                errors++;
                bad++;
                if (bad < 5) $display("FAIL b2b_step%0d got=%h exp=%h", i, got, exp);
            end
        end
        checks++;
        if (nbr != 254 || ndn != 1) begin
            errors++;
            $display("FAIL b2b_pulses got branch=%0d done=%0d exp 254 1", nbr, ndn);
        end
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        load_val = 8'd0;
        step     = 1'b0;
        test_reset();
        test_count3();
        test_load_zero();
        test_reload();
        test_reset_midloop();
        test_ignored_step();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_dbnz_loop_ctrl
`default_nettype wire

// File: doc/dbnz_loop_ctrl.md
DBNZ_LOOP_CTRL -- requirements
Module: dbnz_loop_ctrl

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the loop-count width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port load, input, 1 bit: load load_val into the counter and start a loop.
REQ-005 The module SHALL have port load_val, input, WIDTH bits: initial loop count.
REQ-006 The module SHALL have port step, input, 1 bit: execute one decrement-and-test iteration.
REQ-007 The module SHALL have port count, output, WIDTH bits: current registered counter value.
REQ-008 The module SHALL have port busy, output, 1 bit: high while in state RUN.
REQ-009 The module SHALL have port branch, output, 1 bit: one-cycle pulse when a step leaves a nonzero result (branch taken).
REQ-010 The module SHALL have port done, output, 1 bit: one-cycle pulse when the loop reaches zero (branch not taken, loop exit).
REQ-011 The module SHALL have port zero, output, 1 bit: registered flag, 1 when count equals 0.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE, load=1 with load_val!=0 SHALL set count=load_val and enter RUN on the next edge.
REQ-014 In IDLE, load=1 with load_val==0 SHALL set count=0, enter DONE and pulse done on the next cycle, with no branch pulse.
REQ-015 In IDLE, step SHALL be ignored, and count SHALL hold its value.
REQ-016 In RUN, step=1 (with load=0) SHALL set count=count-1; if the result is !=0, branch SHALL pulse for one cycle and the FSM SHALL stay in RUN; if the result is 0, done SHALL pulse for one cycle and the FSM SHALL enter DONE.
REQ-017 branch and done SHALL be registered and asserted in the cycle after the triggering step edge, and SHALL never be high together.
REQ-018 In RUN, load=1 SHALL take priority over step and restart the loop with load_val, following the same rules as REQ-013 and REQ-014, with no branch or done pulse for the discarded step.
REQ-019 DONE SHALL last exactly one cycle and then return to IDLE, ignoring step and load during that cycle.
REQ-020 The decrement SHALL be modulo 2^WIDTH, but count SHALL never decrement below 0, because RUN is never entered or kept with count=0.
REQ-021 zero SHALL be derived from the registered count and SHALL be valid in the same cycle that count updates.
REQ-022 Back-to-back steps on consecutive cycles SHALL each be honoured, giving one decrement per cycle.

Reset
REQ-023 rst=1 at a clock edge SHALL force state=IDLE, count=0, busy=0, branch=0, done=0 and zero=1.
REQ-024 rst SHALL override load and step in the same cycle, including when asserted mid-loop in RUN or in DONE.

Structure
REQ-025 WIDTH's default and the state encoding (IDLE/RUN/DONE enum) SHALL be defined in the shared package coa_pkg.
REQ-026 The zero test SHALL be implemented as a separate combinational sub-module, zero_det (WIDTH-bit input, 1-bit output).

Verification
REQ-027 The bench SHALL cover: rst, then load_val=3 and step on 3 consecutive cycles -> count 2,1,0; branch pulses twice; done pulses once; busy falls with the final step.
REQ-028 The bench SHALL cover: load_val=0 -> no busy; done pulses one cycle later; zero=1; no branch.
REQ-029 The bench SHALL cover: load_val=5, 2 steps, then load=1 with load_val=2 together with step -> count=2; no branch or done for that cycle.
REQ-030 The bench SHALL cover: rst asserted in RUN with count=4 -> next cycle count=0, IDLE, zero=1, no done pulse.
REQ-031 The bench SHALL cover: step asserted in IDLE and in DONE -> count unchanged; no pulses.
REQ-032 The bench SHALL cover: load_val=255 with WIDTH=8 and 255 consecutive steps -> 254 branch pulses, then 1 done pulse.
